// File: rtl/ipr_obi_mux_pkg.sv
// Shared definitions for the OBI request multiplexer: default widths,
// perf counter width and the round-robin winner picker.
package ipr_obi_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int PERF_CNT_W = 16;
  localparam int MAX_CH     = 32;

  // First requester at or after ptr, wrapping at n; returns ptr when nobody requests.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && req[idx[4:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/ipr_obi_mux_if.sv
// Bus bundle between NUM_CH masters, the multiplexer and the shared slave port.
// The mux uses the slave modport; the surrounding system uses the master modport.
interface ipr_obi_mux_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]          ch_req;
  logic [NUM_CH*ADDR_W-1:0]   ch_addr;
  logic [NUM_CH-1:0]          ch_we;
  logic [NUM_CH*DATA_W/8-1:0] ch_be;
  logic [NUM_CH*DATA_W-1:0]   ch_wdata;
  logic [NUM_CH-1:0]          ch_gnt;
  logic [NUM_CH-1:0]          ch_rvalid;
  logic [NUM_CH*DATA_W-1:0]   ch_rdata;

  logic                       s_req;
  logic [ADDR_W-1:0]          s_addr;
  logic                       s_we;
  logic [DATA_W/8-1:0]        s_be;
  logic [DATA_W-1:0]          s_wdata;
  logic                       s_gnt;
  logic                       s_rvalid;
  logic [DATA_W-1:0]          s_rdata;

  modport slave (
    input  ch_req, ch_addr, ch_we, ch_be, ch_wdata, s_gnt, s_rvalid, s_rdata,
    output ch_gnt, ch_rvalid, ch_rdata, s_req, s_addr, s_we, s_be, s_wdata
  );

  modport master (
    output ch_req, ch_addr, ch_we, ch_be, ch_wdata, s_gnt, s_rvalid, s_rdata,
    input  ch_gnt, ch_rvalid, ch_rdata, s_req, s_addr, s_we, s_be, s_wdata
  );
endinterface

// File: rtl/ipr_obi_mux_id_fifo.sv
// Outstanding-ID FIFO: remembers which channel owns each granted transaction
// so responses are routed back in order.
module ipr_id_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/ipr_obi_mux.sv
// N-channel round-robin OBI request multiplexer with in-order response routing.
// Optional handshake/stall counters when IPR_OBI_MUX_PERF_EN is defined.
module ipr_obi_mux
  import ipr_obi_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ipr_obi_mux_if.slave                 bus,
  output logic                         err_o
`ifdef IPR_OBI_MUX_PERF_EN
  ,
  output logic [NUM_CH*PERF_CNT_W-1:0] perf_gnt_cnt,
  output logic [PERF_CNT_W-1:0]        perf_stall_cnt
`endif
);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BE_W  = DATA_W / 8;

  logic [IDX_W-1:0]  r_rr_ptr, r_hold_idx, w_pick, w_winner, w_head;
  logic              r_hold, r_err;
  logic              w_full, w_empty, w_hs, w_pop;
  logic [NUM_CH-1:0] w_gnt, w_rvalid;
  logic [MAX_CH-1:0] w_req_ext;

  assign w_req_ext = MAX_CH'(bus.ch_req);
  assign w_pick    = IDX_W'(rr_pick(w_req_ext, 32'(r_rr_ptr), NUM_CH));
  // A stalled request keeps its channel until the slave accepts it.
  assign w_winner  = r_hold ? r_hold_idx : w_pick;

  assign bus.s_req    = (|bus.ch_req) & ~w_full;
  assign w_hs         = bus.s_req & bus.s_gnt;
  assign w_pop        = bus.s_rvalid & ~w_empty;
  assign bus.ch_rdata = {NUM_CH{bus.s_rdata}};
  assign bus.ch_gnt   = w_gnt;
  assign bus.ch_rvalid = w_rvalid;
  assign err_o        = r_err;

  always_comb begin
    bus.s_addr  = '0;
    bus.s_we    = 1'b0;
    bus.s_be    = '0;
    bus.s_wdata = '0;
    w_gnt       = '0;
    w_rvalid    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_winner == IDX_W'(c)) begin
        bus.s_addr  = bus.ch_addr[c*ADDR_W +: ADDR_W];
        bus.s_we    = bus.ch_we[c];
        bus.s_be    = bus.ch_be[c*BE_W +: BE_W];
        bus.s_wdata = bus.ch_wdata[c*DATA_W +: DATA_W];
        w_gnt[c]    = w_hs;
      end
      w_rvalid[c] = w_pop && (w_head == IDX_W'(c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_rr_ptr <= (w_winner == IDX_W'(NUM_CH - 1)) ? '0 : w_winner + 1'b1;
        r_hold   <= 1'b0;
      end else if (bus.s_req) begin
        r_hold     <= 1'b1;
        r_hold_idx <= w_winner;
      end
      if (bus.s_rvalid && w_empty) r_err <= 1'b1;
    end
  end

  ipr_id_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_hs),
    .i_data  (w_winner),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

`ifdef IPR_OBI_MUX_PERF_EN
  logic [PERF_CNT_W-1:0] r_gnt_cnt [NUM_CH];
  logic [PERF_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) r_gnt_cnt[c] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (w_gnt[c] && (r_gnt_cnt[c] != '1)) r_gnt_cnt[c] <= r_gnt_cnt[c] + 1'b1;
      if ((|bus.ch_req) && !w_hs && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) perf_gnt_cnt[c*PERF_CNT_W +: PERF_CNT_W] = r_gnt_cnt[c];
  end
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
